// File: rtl/mem8x32_burst_reader_pkg.sv
// Shared types and sizes for the 8 x 32 register-memory burst reader.
package mem8x32_pkg;

  localparam int DEPTH = 8;
  localparam int WIDTH = 32;
  localparam int AW    = $clog2(DEPTH);

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [AW-1:0]    addr_t;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_e;

endpackage

// File: rtl/mem8x32_burst_reader_rd_out_stage.sv
// Registered valid/ready output stage of the burst reader; holds the word under backpressure.
// Optional RD_PARITY_EN adds a parity bit registered alongside rd_data.
module rd_out_stage
  import mem8x32_pkg::*;
(
  input  logic  clk,
  input  logic  resetn,
  input  logic  load,
  input  logic  flush,
  input  logic  rd_ready,
  input  word_t load_data,
  input  addr_t load_addr,
  input  logic  load_last,
  output logic  rd_valid,
  output word_t rd_data,
  output addr_t rd_addr,
`ifdef RD_PARITY_EN
  output logic  rd_parity,
`endif
  output logic  rd_last
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_addr  <= '0;
      rd_last  <= 1'b0;
`ifdef RD_PARITY_EN
      rd_parity <= 1'b0;
`endif
    end else if (flush) begin
      // data and address keep their last value on abort
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else if (load) begin
      rd_valid <= 1'b1;
      rd_data  <= load_data;
      rd_addr  <= load_addr;
      rd_last  <= load_last;
`ifdef RD_PARITY_EN
      rd_parity <= ^load_data;
`endif
    end else if (rd_valid && rd_ready) begin
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/mem8x32_burst_reader.sv
// Burst read engine for the 8 x 32 register memory: wrapping address walk, valid/ready output.
// Optional RD_PARITY_EN exposes rd_parity (XOR of the registered word).
module mem8x32_burst_reader
  import mem8x32_pkg::*;
(
  input  logic  clk,
  input  logic  resetn,
  input  word_t mem_words [DEPTH],
  input  logic  req_valid,
  output logic  req_ready,
  input  addr_t req_addr,
  input  addr_t req_len,
  output logic  rd_valid,
  input  logic  rd_ready,
  output word_t rd_data,
  output addr_t rd_addr,
  output logic  rd_last,
`ifdef RD_PARITY_EN
  output logic  rd_parity,
`endif
  input  logic  rd_flush,
  output logic  busy
);

  rd_state_e state, state_nxt;
  addr_t     ptr;
  addr_t     rem;
  logic      all_loaded;
  logic      load;
  logic      last_hs;

  // flush wins over a pending load
  assign load    = (state == READ) && !all_loaded && (!rd_valid || rd_ready) && !rd_flush;
  assign last_hs = rd_valid && rd_ready && rd_last;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = READ;
      end
      READ: begin
        busy = 1'b1;
        if (rd_flush || last_hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr        <= '0;
      rem        <= '0;
      all_loaded <= 1'b0;
    end else if (state == IDLE && req_valid) begin
      ptr        <= req_addr;
      rem        <= req_len;
      all_loaded <= 1'b0;
    end else if (load) begin
      // DEPTH is a power of two, so the natural AW-bit overflow is the wrap
      ptr <= ptr + addr_t'(1);
      rem <= rem - addr_t'(1);
      if (rem == '0) all_loaded <= 1'b1;
    end
  end

  rd_out_stage u_out (
    .clk       (clk),
    .resetn    (resetn),
    .load      (load),
    .flush     (rd_flush && (state == READ)),
    .rd_ready  (rd_ready),
    .load_data (mem_words[ptr]),
    .load_addr (ptr),
    .load_last (rem == '0),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_addr   (rd_addr),
`ifdef RD_PARITY_EN
    .rd_parity (rd_parity),
`endif
    .rd_last   (rd_last)
  );

endmodule

// File: doc/mem8x32_burst_reader.md
Name: mem8x32_burst_reader

Overview:
Read-side engine for the 8 x 32 D-FF register memory. It accepts a burst read request (start address, length), walks the addresses with wrap-around, and samples the memory's parallel register outputs. Each word is presented on a registered valid/ready output stream. It sits between the register memory and any consumer that needs sequenced, back-pressurable reads, e.g. a bus slave or DMA.

Parameters:
DEPTH, 8, number of memory words; must be a power of 2
WIDTH, 32, bits per word
AW, $clog2(DEPTH) = 3, address width

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
mem_words  in  WIDTH x DEPTH  unpacked array, parallel register outputs of the memory
req_valid  in  1  burst request present
req_ready  out  1  engine can accept a request
req_addr  in  AW  start address
req_len  in  AW  beats minus 1 (0 = 1 beat, 7 = 8 beats)
rd_valid  out  1  rd_data holds a valid word
rd_ready  in  1  consumer accepts the word
rd_data  out  WIDTH  word read
rd_addr  out  AW  address of rd_data
rd_last  out  1  final beat of the burst
rd_flush  in  1  synchronous abort of the current burst
busy  out  1  burst in progress (state != IDLE)

Behaviour:
- Reset (async, resetn=0): state=IDLE; rd_valid=0; rd_data=0; rd_addr=0; rd_last=0; busy=0; req_ready=1. Internal ptr and remaining count are cleared to 0. Reset mid-burst discards the burst with no further beats.
- FSM states: IDLE and READ.
  - IDLE: req_ready=1. On req_valid=1, capture ptr=req_addr and rem=req_len, then go to READ.
  - READ: req_ready=0. The engine goes to IDLE on the cycle the last beat is handshaken (rd_valid & rd_ready & rd_last), or on rd_flush.
- Output register load condition: state==READ, a beat is still pending, and (rd_valid==0 or rd_ready==1).
  - On load: rd_data=mem_words[ptr], rd_addr=ptr, rd_last=(rem==0), rd_valid=1.
  - Then ptr=ptr+1 modulo DEPTH (7 wraps to 0), and rem decrements.
- An internal flag marks that all beats have been loaded. Once it is set, no further loads occur. rd_valid clears after the final handshake.
- Latency:
  - The request is accepted at edge N; the first rd_valid is high after edge N+1.
  - With rd_ready held at 1, there is one beat per cycle, so an 8-beat burst occupies 8 consecutive cycles.
  - The next request is accepted no earlier than the cycle after the last handshake. This gives a one-cycle bubble between bursts.
- Backpressure: while rd_valid=1 and rd_ready=0, rd_data, rd_addr and rd_last hold stable, and the word is not re-sampled.
- Coherence: the word is sampled at its load edge. A memory write that commits on the same edge is not visible; the pre-write value is read.
- rd_flush: takes priority over load and handshake. Next cycle: rd_valid=0, rd_last=0, state=IDLE. rd_data and rd_addr keep their last value. A req_valid in the flush cycle is ignored, because req_ready=0 in READ.
- rd_flush in IDLE has no effect.
- req_len is never out of range, because the field width limits it to DEPTH-1.

Optional Feature:
Macro RD_PARITY_EN.
- Defined: adds output port rd_parity (1 bit), equal to the even parity (XOR reduction) of the word loaded into rd_data. It is registered with rd_data, follows the same hold and reset rules, and resets to 0.
- Undefined: the port and its logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package mem8x32_pkg holds:
  - localparams DEPTH, WIDTH, AW
  - typedef word_t = logic [WIDTH-1:0]
  - typedef addr_t = logic [AW-1:0]
  - enum rd_state_e {IDLE, READ}
- One natural sub-module, rd_out_stage: the output register with valid/ready hold logic and the optional parity bit. The FSM, pointer and remaining count stay in the top-level module.

Test Plan:
1. Memory preloaded with word[i]=32'h1000_0000+i. Request addr=2, len=3, rd_ready=1 → beats 1000_0002..1000_0005 on consecutive cycles, rd_addr 2,3,4,5, rd_last only on addr 5, first beat one cycle after acceptance.
2. Wrap-around: addr=6, len=3 → rd_addr sequence 6,7,0,1 with matching data; busy drops after the beat at addr 1.
3. Backpressure: addr=0, len=1, rd_ready low for 3 cycles on the first beat → rd_data=1000_0000 held stable for 3 cycles, then the two beats complete in order with no loss or duplication.
4. Flush: 8-beat burst, rd_flush asserted on the 3rd beat → rd_valid=0 next cycle, state IDLE, req_ready=1; a new request at addr=4, len=0 then returns 1000_0004 with rd_last=1.
5. Async reset: resetn pulsed low mid-burst → all outputs take their reset values immediately; no beats after release until a new request.
6. RD_PARITY_EN: word 32'h0000_0007 → rd_parity=1; word 32'h0000_0003 → rd_parity=0. With write-then-read in the same cycle to the same address, the old value is returned.
